if_id_hazard_stage: RTL and testbench
=====================================

Name: if_id_hazard_stage

Overview:
- IF/ID pipeline register with integrated load-use hazard detection and branch flush.
- Sits directly downstream of the fetch stage: captures PC_IF/INSTRUCTION_IF, presents them to decode, and drives fetch's PC_write.
- Requests a one-cycle ID/EX bubble on load-use hazards and squashes the wrong-path instruction when a branch resolves taken.

Parameters:
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) loaded on flush/reset.
- PC_RESET, 32'h00000000, PC_ID value after reset/flush.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- PC_IF  in  32  PC of fetched instruction.
- INSTRUCTION_IF  in  32  fetched instruction word.
- PCSrc  in  1  branch/jump resolved taken this cycle (same signal fetch uses).
- hold  in  1  external freeze (memory busy); whole front end holds.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_rd  in  5  destination register of instruction in EX.
- PC_write  out  1  fetch PC enable.
- PC_ID  out  32  registered PC for decode.
- INSTRUCTION_ID  out  32  registered instruction for decode.
- valid_ID  out  1  INSTRUCTION_ID is a real (non-bubble) instruction.
- ID_EX_flush  out  1  zero ID/EX control signals next edge.

Behaviour:
- Reset (reset=0, async):
  - PC_ID=PC_RESET, INSTRUCTION_ID=NOP_INSTR, valid_ID=0, state=RUN.
  - PC_write=0, ID_EX_flush=0 while reset is low.
- Source-register decode from INSTRUCTION_ID opcode [6:0]:
  - uses_rs1 for 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - uses_rs2 for 0110011, 0100011, 1100011.
  - rs1=[19:15], rs2=[24:20].
- Hazard (combinational):
  - hz = valid_ID & ID_EX_MemRead & (ID_EX_rd!=0) & ((uses_rs1 & rs1==ID_EX_rd) | (uses_rs2 & rs2==ID_EX_rd)).
  - hz is forced to 0 in state STALL.
- FSM states:
  - RUN: normal operation.
  - STALL: exactly one cycle after a load-use detect. Guarantees a single bubble even if ID_EX_MemRead is still high.
- Per-cycle priority (highest first), all register updates on the rising edge:
  1. PCSrc=1: load NOP_INSTR/PC_RESET, valid_ID=0, ID_EX_flush=1, PC_write=1, next=RUN. Wins over hold and hz.
  2. hold=1: registers and state unchanged; PC_write=0, ID_EX_flush=0.
  3. hz=1 (RUN only): registers hold; PC_write=0, ID_EX_flush=1, next=STALL.
  4. Otherwise: capture PC_IF/INSTRUCTION_IF, valid_ID=1, PC_write=1, ID_EX_flush=0, next=RUN.
- STALL with hold=0 and PCSrc=0: capture as case 4 and return to RUN.
- STALL with hold=1: remain in STALL.
- Latency: an instruction at PC_IF appears on INSTRUCTION_ID one clock later. A load-use dependency costs exactly 1 cycle.
- PC_write and ID_EX_flush are combinational from state and inputs; no internal registers on them.
- Reset asserted mid-stall returns to RUN with a bubble. The first edge after reset release captures fetch output.

Optional Feature:
- Macro: IF_ID_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs stall_count[31:0] and flush_count[31:0], both reset to 0.
  - stall_count increments on each case-3 cycle.
  - flush_count increments on each case-1 cycle.
  - Both wrap from 32'hFFFFFFFF to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset release, then PC_IF=0x0, INSTRUCTION_IF=0x00500093 -> after 1 edge PC_ID=0x0, INSTRUCTION_ID=0x00500093, valid_ID=1, PC_write=1.
- INSTRUCTION_ID=0x002081B3 (add x3,x1,x2) with ID_EX_MemRead=1, ID_EX_rd=2 -> PC_write=0, ID_EX_flush=1 for exactly one cycle, state STALL. Next edge captures new fetch and returns to RUN.
- Same hazard but ID_EX_rd=0, or INSTRUCTION_ID=0x000000B7 (lui, no rs) -> no stall, PC_write=1.
- PCSrc=1 during a detected hazard with hold=1 -> next edge INSTRUCTION_ID=0x00000013, valid_ID=0, ID_EX_flush=1 that cycle, PC_write=1.
- hold=1 for 3 cycles -> PC_ID/INSTRUCTION_ID unchanged, PC_write=0. Release resumes capture.
- With IF_ID_PERF_COUNTERS_EN: 2 load-use stalls and 3 taken branches -> stall_count=2, flush_count=3. reset=0 mid-run -> both read 0 immediately.

Source files
------------

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use hazard detection, one-cycle stall FSM and branch flush.
// Optional performance counters are enabled by defining IF_ID_PERF_COUNTERS_EN.
module if_id_hazard_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter logic [31:0] PC_RESET  = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_IF,
    input  logic [31:0] INSTRUCTION_IF,
    input  logic        PCSrc,
    input  logic        hold,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_rd,
    output logic        PC_write,
    output logic [31:0] PC_ID,
    output logic [31:0] INSTRUCTION_ID,
    output logic        valid_ID,
    output logic        ID_EX_flush
`ifdef IF_ID_PERF_COUNTERS_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    function automatic logic uses_rs1_f(input logic [6:0] opcode);
        logic r;
        case (opcode)
            OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: r = 1'b1;
            default:                                              r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic uses_rs2_f(input logic [6:0] opcode);
        logic r;
        case (opcode)
            OP_REG, OP_STORE, OP_BRANCH: r = 1'b1;
            default:                     r = 1'b0;
        endcase
        return r;
    endfunction

    logic [31:0] pc_id_r;
    logic [31:0] instr_id_r;
    logic        valid_id_r;
    logic [0:0]  state_r;

    logic        uses_rs1_s;
    logic        uses_rs2_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic        rs_match_s;
    logic        hz_s;
    logic        pc_write_s;
    logic        id_ex_flush_s;

    // Source-register decode and load-use detection on the instruction held in ID
    always_comb begin
        uses_rs1_s = uses_rs1_f(instr_id_r[6:0]);
        uses_rs2_s = uses_rs2_f(instr_id_r[6:0]);
        rs1_s      = instr_id_r[19:15];
        rs2_s      = instr_id_r[24:20];
        rs_match_s = (uses_rs1_s && (rs1_s == ID_EX_rd)) ||
                     (uses_rs2_s && (rs2_s == ID_EX_rd));
        if (state_r == STALL) begin
            hz_s = 1'b0;
        end else begin
            hz_s = valid_id_r && ID_EX_MemRead && (ID_EX_rd != 5'd0) && rs_match_s;
        end
    end

    // Fetch enable and ID/EX bubble request, by priority: reset, branch, hold, hazard, run
    always_comb begin
        pc_write_s    = 1'b0;
        id_ex_flush_s = 1'b0;
        if (!reset) begin
            pc_write_s    = 1'b0;
            id_ex_flush_s = 1'b0;
        end else if (PCSrc) begin
            pc_write_s    = 1'b1;
            id_ex_flush_s = 1'b1;
        end else if (hold) begin
            pc_write_s    = 1'b0;
            id_ex_flush_s = 1'b0;
        end else if (hz_s) begin
            pc_write_s    = 1'b0;
            id_ex_flush_s = 1'b1;
        end else begin
            pc_write_s    = 1'b1;
            id_ex_flush_s = 1'b0;
        end
    end

    // Pipeline register and stall state; a taken branch squashes the wrong-path slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_id_r    <= PC_RESET;
            instr_id_r <= NOP_INSTR;
            valid_id_r <= 1'b0;
            state_r    <= RUN;
        end else if (PCSrc) begin
            pc_id_r    <= PC_RESET;
            instr_id_r <= NOP_INSTR;
            valid_id_r <= 1'b0;
            state_r    <= RUN;
        end else if (hold) begin
            pc_id_r    <= pc_id_r;
            instr_id_r <= instr_id_r;
            valid_id_r <= valid_id_r;
            state_r    <= state_r;
        end else if (hz_s) begin
            pc_id_r    <= pc_id_r;
            instr_id_r <= instr_id_r;
            valid_id_r <= valid_id_r;
            state_r    <= STALL;
        end else begin
            pc_id_r    <= PC_IF;
            instr_id_r <= INSTRUCTION_IF;
            valid_id_r <= 1'b1;
            state_r    <= RUN;
        end
    end

    assign PC_write       = pc_write_s;
    assign ID_EX_flush    = id_ex_flush_s;
    assign PC_ID          = pc_id_r;
    assign INSTRUCTION_ID = instr_id_r;
    assign valid_ID       = valid_id_r;

`ifdef IF_ID_PERF_COUNTERS_EN
    logic [31:0] stall_count_r;
    logic [31:0] flush_count_r;

    // Event counters: load-use bubbles and taken-branch squashes, free-running with wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_r <= 32'd0;
            flush_count_r <= 32'd0;
        end else if (PCSrc) begin
            stall_count_r <= stall_count_r;
            flush_count_r <= flush_count_r + 32'd1;
        end else if (!hold && hz_s) begin
            stall_count_r <= stall_count_r + 32'd1;
            flush_count_r <= flush_count_r;
        end else begin
            stall_count_r <= stall_count_r;
            flush_count_r <= flush_count_r;
        end
    end

    assign stall_count = stall_count_r;
    assign flush_count = flush_count_r;
`endif

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Randomized self-checking bench for if_id_hazard_stage against a behavioural front-end model.
module tb_if_id_hazard_stage;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] PCR = 32'h00000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_if;
    logic [31:0] instr_if;
    logic        pcsrc;
    logic        hold;
    logic        memread;
    logic [4:0]  ex_rd;
    logic        pc_write;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        valid_id;
    logic        ex_flush;
`ifdef IF_ID_PERF_COUNTERS_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    if_id_hazard_stage dut (
        .clk(clk), .reset(reset), .PC_IF(pc_if), .INSTRUCTION_IF(instr_if),
        .PCSrc(pcsrc), .hold(hold), .ID_EX_MemRead(memread), .ID_EX_rd(ex_rd),
        .PC_write(pc_write), .PC_ID(pc_id), .INSTRUCTION_ID(instr_id),
        .valid_ID(valid_id), .ID_EX_flush(ex_flush)
`ifdef IF_ID_PERF_COUNTERS_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    // Behavioural model: contents of the decode slot plus "a bubble was just inserted"
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_valid;
    bit          m_bubbled;
    logic [31:0] m_stalls;
    logic [31:0] m_flushes;

    logic [6:0] rs1_ops [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                7'b0100011, 7'b1100011, 7'b1100111};
    logic [6:0] rs2_ops [3] = '{7'b0110011, 7'b0100011, 7'b1100011};
    logic [6:0] all_ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1100111, 7'b0110111, 7'b1101111};

    function automatic bit reads_rs1(logic [6:0] op);
        foreach (rs1_ops[i]) if (rs1_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit reads_rs2(logic [6:0] op);
        foreach (rs2_ops[i]) if (rs2_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_hz();
        bit dep;
        dep = (reads_rs1(m_instr[6:0]) && m_instr[19:15] == ex_rd) ||
              (reads_rs2(m_instr[6:0]) && m_instr[24:20] == ex_rd);
        return m_valid && !m_bubbled && memread && (ex_rd != 5'd0) && dep;
    endfunction

    task automatic model_reset();
        m_pc = PCR; m_instr = NOP; m_valid = 1'b0; m_bubbled = 1'b0;
        m_stalls = 32'd0; m_flushes = 32'd0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all();
        bit hz;
        bit exp_pcw;
        bit exp_fl;
        hz      = model_hz();
        exp_pcw = reset && (pcsrc || (!hold && !hz));
        exp_fl  = reset && (pcsrc || (!hold && hz));
        check("PC_ID", pc_id, m_pc);
        check("INSTRUCTION_ID", instr_id, m_instr);
        check("valid_ID", {31'd0, valid_id}, {31'd0, m_valid});
        check("PC_write", {31'd0, pc_write}, {31'd0, exp_pcw});
        check("ID_EX_flush", {31'd0, ex_flush}, {31'd0, exp_fl});
`ifdef IF_ID_PERF_COUNTERS_EN
        check("stall_count", stall_count, m_stalls);
        check("flush_count", flush_count, m_flushes);
`endif
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins,
                         input bit pcs, input bit hld, input bit mr, input logic [4:0] rd);
        pc_if = pc; instr_if = ins; pcsrc = pcs; hold = hld; memread = mr; ex_rd = rd;
    endtask

    // One clock: drive at the falling edge, check, then advance the model at the rising edge
    task automatic cycle(input logic [31:0] pc, input logic [31:0] ins,
                         input bit pcs, input bit hld, input bit mr, input logic [4:0] rd);
        bit hz;
        drive(pc, ins, pcs, hld, mr, rd);
        #1;
        check_all();
        hz = model_hz();
        @(posedge clk);
        if (pcs) begin
            m_pc = PCR; m_instr = NOP; m_valid = 1'b0; m_bubbled = 1'b0;
            m_flushes = m_flushes + 32'd1;
        end else if (!hld) begin
            if (hz) begin
                m_bubbled = 1'b1;
                m_stalls  = m_stalls + 32'd1;
            end else begin
                m_pc = pc; m_instr = ins; m_valid = 1'b1; m_bubbled = 1'b0;
            end
        end
        #1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        reset = 1'b0;
        drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        #1;
        check_all();
        check("rst PC_ID", pc_id, 32'h0);
        check("rst INSTRUCTION_ID", instr_id, 32'h00000013);
        check("rst valid_ID", {31'd0, valid_id}, 32'd0);
        check("rst PC_write", {31'd0, pc_write}, 32'd0);
        check("rst ID_EX_flush", {31'd0, ex_flush}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        cycle(32'h0, 32'h00500093, 1'b0, 1'b0, 1'b0, 5'd0);
        check("first PC_ID", pc_id, 32'h0);
        check("first INSTRUCTION_ID", instr_id, 32'h00500093);
        check("first valid_ID", {31'd0, valid_id}, 32'd1);
        drive(32'h4, 32'h002081B3, 1'b0, 1'b0, 1'b0, 5'd0);
        #1 check("first PC_write", {31'd0, pc_write}, 32'd1);
        cycle(32'h4, 32'h002081B3, 1'b0, 1'b0, 1'b0, 5'd0);

        drive(32'h8, 32'h00000013, 1'b0, 1'b0, 1'b1, 5'd2);
        #1 check("lu PC_write", {31'd0, pc_write}, 32'd0);
        check("lu ID_EX_flush", {31'd0, ex_flush}, 32'd1);
        cycle(32'h8, 32'h00000013, 1'b0, 1'b0, 1'b1, 5'd2);
        check("lu held INSTRUCTION_ID", instr_id, 32'h002081B3);
        drive(32'h8, 32'h00000013, 1'b0, 1'b0, 1'b1, 5'd2);
        #1 check("stall PC_write", {31'd0, pc_write}, 32'd1);
        check("stall ID_EX_flush", {31'd0, ex_flush}, 32'd0);
        cycle(32'h8, 32'h00000013, 1'b0, 1'b0, 1'b1, 5'd2);
        check("after stall PC_ID", pc_id, 32'h8);

        cycle(32'hC, 32'h002081B3, 1'b0, 1'b0, 1'b0, 5'd0);
        drive(32'h10, 32'h000000B7, 1'b0, 1'b0, 1'b1, 5'd0);
        #1 check("rd0 PC_write", {31'd0, pc_write}, 32'd1);
        cycle(32'h10, 32'h000000B7, 1'b0, 1'b0, 1'b1, 5'd0);
        drive(32'h14, 32'h002081B3, 1'b0, 1'b0, 1'b1, 5'd1);
        #1 check("lui PC_write", {31'd0, pc_write}, 32'd1);
        cycle(32'h14, 32'h002081B3, 1'b0, 1'b0, 1'b1, 5'd1);

        drive(32'h18, 32'h00A00113, 1'b1, 1'b1, 1'b1, 5'd2);
        #1 check("br PC_write", {31'd0, pc_write}, 32'd1);
        check("br ID_EX_flush", {31'd0, ex_flush}, 32'd1);
        cycle(32'h18, 32'h00A00113, 1'b1, 1'b1, 1'b1, 5'd2);
        check("br INSTRUCTION_ID", instr_id, 32'h00000013);
        check("br valid_ID", {31'd0, valid_id}, 32'd0);

        cycle(32'h1C, 32'h00500093, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            drive(32'h20, 32'h11111111, 1'b0, 1'b1, 1'b0, 5'd0);
            #1 check("hold PC_write", {31'd0, pc_write}, 32'd0);
            cycle(32'h20, 32'h11111111, 1'b0, 1'b1, 1'b0, 5'd0);
            check("hold PC_ID", pc_id, 32'h1C);
        end
        cycle(32'h20, 32'h00A00113, 1'b0, 1'b0, 1'b0, 5'd0);
        check("release PC_ID", pc_id, 32'h20);
`ifdef IF_ID_PERF_COUNTERS_EN
        check("directed stall_count", stall_count, 32'd1);
        check("directed flush_count", flush_count, 32'd1);
`endif

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                ins = $urandom;
                ins[6:0]   = all_ops[$urandom_range(0, 7)];
                ins[19:15] = 5'($urandom_range(0, 3));
                ins[24:20] = 5'($urandom_range(0, 3));
                cycle($urandom, ins, ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0),
                      ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
